// File: rtl/cordic_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cordic_pkg : angle format and arctangent table shared by the CORDIC blocks |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package cordic_pkg;

  localparam int ANGLE_WIDTH  = 20;
  localparam int ATAN_ENTRIES = 16;

  typedef logic [ANGLE_WIDTH-1:0] angle_t;

  localparam angle_t ANGLE_180 = 20'h80000;

  // round(atan(2^-i) / 360 * 2^20)
  localparam angle_t ATAN_TABLE [ATAN_ENTRIES] = '{
    20'd131072, 20'd77376, 20'd40884, 20'd20753,
    20'd10417,  20'd5213,  20'd2607,  20'd1304,
    20'd652,    20'd326,   20'd163,   20'd81,
    20'd41,     20'd20,    20'd10,    20'd5
  };

endpackage
`default_nettype wire

// File: rtl/cordic_vec_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cordic_vec_stage : one registered vectoring micro-rotation by 2^-SHIFT     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module cordic_vec_stage
  import cordic_pkg::*;
#(
  parameter int WIDTH = 14,
  parameter int SHIFT = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_en,
  input  logic                    i_valid,
  input  logic                    i_zero,
  input  logic signed [WIDTH-1:0] i_x,
  input  logic signed [WIDTH-1:0] i_y,
  input  angle_t                  i_z,
  output logic                    o_valid,
  output logic                    o_zero,
  output logic signed [WIDTH-1:0] o_x,
  output logic signed [WIDTH-1:0] o_y,
  output angle_t                  o_z
);

  localparam angle_t c_atan = ATAN_TABLE[SHIFT];

  logic                    r_valid;
  logic                    r_zero;
  logic signed [WIDTH-1:0] r_x;
  logic signed [WIDTH-1:0] r_y;
  angle_t                  r_z;

  logic signed [WIDTH-1:0] w_x_sh;
  logic signed [WIDTH-1:0] w_y_sh;
  logic signed [WIDTH-1:0] w_x_nxt;
  logic signed [WIDTH-1:0] w_y_nxt;
  angle_t                  w_z_nxt;

  // Rotate towards the positive x axis, driving y to zero.
  always_comb begin
    w_x_sh = i_x >>> SHIFT;
    w_y_sh = i_y >>> SHIFT;
    if (!i_y[WIDTH-1]) begin
      w_x_nxt = i_x + w_y_sh;
      w_y_nxt = i_y - w_x_sh;
      w_z_nxt = i_z + c_atan;
    end else begin
      w_x_nxt = i_x - w_y_sh;
      w_y_nxt = i_y + w_x_sh;
      w_z_nxt = i_z - c_atan;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_zero  <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
    end else if (i_en) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_zero <= i_zero;
        r_x    <= w_x_nxt;
        r_y    <= w_y_nxt;
        r_z    <= w_z_nxt;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_zero  = r_zero;
  assign o_x     = r_x;
  assign o_y     = r_y;
  assign o_z     = r_z;

endmodule
`default_nettype wire

// File: rtl/cordic_vectoring.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cordic_vectoring : pipelined (x,y) -> (K*|v|, atan2(y,x)) converter        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module cordic_vectoring
  import cordic_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int STAGES     = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] x_in,
  input  logic signed [DATA_WIDTH-1:0] y_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic        [DATA_WIDTH+1:0] mag_out,
  output logic signed [ANGLE_WIDTH-1:0] phase_out
);

  localparam int c_xw = DATA_WIDTH + 2;

  logic                   w_en;
  logic signed [c_xw-1:0] w_x_ext;
  logic signed [c_xw-1:0] w_y_ext;

  logic                   r_valid0;
  logic                   r_zero0;
  logic signed [c_xw-1:0] r_x0;
  logic signed [c_xw-1:0] r_y0;
  angle_t                 r_z0;

  // Index 0 is the pre-rotation register, index i+1 is the output of stage i.
  logic                   w_valid [STAGES+1];
  logic                   w_zero  [STAGES+1];
  logic signed [c_xw-1:0] w_x     [STAGES+1];
  logic signed [c_xw-1:0] w_y     [STAGES+1];
  angle_t                 w_z     [STAGES+1];

  assign w_en     = !out_valid || out_ready;
  assign in_ready = w_en;

  // Widen first so that negating the most negative input cannot overflow.
  assign w_x_ext = {{2{x_in[DATA_WIDTH-1]}}, x_in};
  assign w_y_ext = {{2{y_in[DATA_WIDTH-1]}}, y_in};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid0 <= 1'b0;
      r_zero0  <= 1'b0;
      r_x0     <= '0;
      r_y0     <= '0;
      r_z0     <= '0;
    end else if (w_en) begin
      r_valid0 <= in_valid;
      if (in_valid) begin
        r_zero0 <= (x_in == '0) && (y_in == '0);
        if (x_in[DATA_WIDTH-1]) begin
          r_x0 <= -w_x_ext;
          r_y0 <= -w_y_ext;
          r_z0 <= ANGLE_180;
        end else begin
          r_x0 <= w_x_ext;
          r_y0 <= w_y_ext;
          r_z0 <= '0;
        end
      end
    end
  end

  assign w_valid[0] = r_valid0;
  assign w_zero[0]  = r_zero0;
  assign w_x[0]     = r_x0;
  assign w_y[0]     = r_y0;
  assign w_z[0]     = r_z0;

  generate
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
      cordic_vec_stage #(
        .WIDTH (c_xw),
        .SHIFT (i)
      ) u_stage (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_en),
        .i_valid (w_valid[i]),
        .i_zero  (w_zero[i]),
        .i_x     (w_x[i]),
        .i_y     (w_y[i]),
        .i_z     (w_z[i]),
        .o_valid (w_valid[i+1]),
        .o_zero  (w_zero[i+1]),
        .o_x     (w_x[i+1]),
        .o_y     (w_y[i+1]),
        .o_z     (w_z[i+1])
      );
    end
  endgenerate

  // The zero flag overrides the meaningless angle accumulated for a null vector.
  assign out_valid = w_valid[STAGES];
  assign mag_out   = w_zero[STAGES] ? '0 : w_x[STAGES];
  assign phase_out = w_zero[STAGES] ? '0 : w_z[STAGES];

endmodule
`default_nettype wire

// File: tb/tb_cordic_vectoring.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_cordic_vectoring : randomized bench with a real-arithmetic reference    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_cordic_vectoring;

  localparam int DW = 12;
  localparam int ST = 10;
  localparam int AW = 20;
  localparam real PI = 3.14159265358979323846;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] x_in;
  logic signed [DW-1:0] y_in;
  logic                 out_valid;
  logic                 out_ready;
  logic        [DW+1:0] mag_out;
  logic signed [AW-1:0] phase_out;

  always #5 clk = ~clk;

  cordic_vectoring #(
    .DATA_WIDTH (DW),
    .STAGES     (ST)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .y_in      (y_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .mag_out   (mag_out),
    .phase_out (phase_out)
  );

  typedef struct {
    int x;
    int y;
    int idx;
  } samp_t;

  int    tests = 0;
  int    fails = 0;
  samp_t q[$];
  int    en_count = 0;
  bit    last_en = 1'b0;
  bit    prev_ov = 1'b0;
  longint prev_mag = 0;
  longint prev_ph = 0;
  bit    rand_ready = 1'b0;
  real   gain;

  initial begin
    gain = 1.0;
    for (int i = 0; i < ST; i++) gain = gain * $sqrt(1.0 + 1.0 / (4.0 ** i));
  end

  task automatic chk(input string name, input longint act, input longint exp, input longint tol);
    tests++;
    if (act - exp > tol || exp - act > tol) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (+/-%0d) at %0t", name, act, exp, tol, $time);
    end
  endtask

  function automatic longint wrap20(input longint d);
    longint m;
    m = ((d % 1048576) + 1048576) % 1048576;
    if (m >= 524288) m = m - 1048576;
    return m;
  endfunction

  // Hand-computed expectations for the named corner vectors.
  function automatic bit literal_exp(input int x, input int y, output longint m, output longint p);
    m = 0; p = 0;
    if (x == 1000 && y == 0)            begin m = 1647; p = 0;       return 1'b1; end
    if (x == 0 && y == 1000)            begin m = 1647; p = 262144;  return 1'b1; end
    if (x == -1000 && y == 0)           begin m = 1647; p = -524288; return 1'b1; end
    if (x == -2048 && y == -2048)       begin m = 4770; p = -393216; return 1'b1; end
    return 1'b0;
  endfunction

  task automatic check_result(input samp_t s);
    longint em, ep, tm, tp, d;
    real r;
    if (literal_exp(s.x, s.y, em, ep)) begin
      tm = 4; tp = 512;
    end else if (s.x == 0 && s.y == 0) begin
      em = 0; ep = 0; tm = 0; tp = 0;
    end else begin
      r  = $sqrt(real'(s.x * s.x + s.y * s.y));
      em = longint'(gain * r);
      ep = longint'($atan2(real'(s.y), real'(s.x)) / (2.0 * PI) * 1048576.0);
      tm = 12;
      tp = 512 + longint'(12.0 * 166886.0 / (gain * r));
    end
    chk("mag", longint'(mag_out), em, tm);
    d = wrap20(longint'(phase_out) - ep);
    tests++;
    if (d > tp || -d > tp) begin
      fails++;
      $display("FAIL phase (x=%0d y=%0d): got %0d, expected %0d (+/-%0d)", s.x, s.y, longint'(phase_out), ep, tp);
    end
  endtask

  // Outputs are observed mid-cycle; the decision for the coming edge is taken here too.
  always @(negedge clk) begin
    samp_t s;
    if (rst) begin
      chk("rst_out_valid", longint'(out_valid), 0, 0);
      chk("rst_mag", longint'(mag_out), 0, 0);
      chk("rst_phase", longint'(phase_out), 0, 0);
      chk("rst_in_ready", longint'(in_ready), 1, 0);
      q.delete();
      last_en  = 1'b0;
      prev_ov  = 1'b0;
      prev_mag = 0;
      prev_ph  = 0;
    end else begin
      chk("in_ready", longint'(in_ready), longint'(!out_valid || out_ready), 0);
      if (last_en) begin
        if (out_valid) begin
          if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_result: got mag=%0d phase=%0d, expected no result", mag_out, phase_out);
          end else begin
            s = q.pop_front();
            check_result(s);
            chk("latency", longint'(en_count), longint'(s.idx + ST + 1), 0);
          end
        end
      end else begin
        chk("hold_valid", longint'(out_valid), longint'(prev_ov), 0);
        chk("hold_mag", longint'(mag_out), prev_mag, 0);
        chk("hold_phase", longint'(phase_out), prev_ph, 0);
      end
      prev_ov  = out_valid;
      prev_mag = longint'(mag_out);
      prev_ph  = longint'(phase_out);
      last_en  = in_ready;
      if (in_ready) begin
        if (in_valid) q.push_back('{int'(x_in), int'(y_in), en_count});
        en_count++;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic send(input int x, input int y);
    bit acc;
    int n;
    n = 0;
    in_valid = 1'b1;
    x_in = DW'(x);
    y_in = DW'(y);
    forever begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      n++;
      if (n > 1000) begin
        tests++;
        fails++;
        $display("FAIL send_timeout: got no acceptance in %0d cycles, expected acceptance", n);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rand_xy(output int x, output int y);
    do begin
      x = int'($urandom_range(0, 4095)) - 2048;
      y = int'($urandom_range(0, 4095)) - 2048;
    end while (x * x + y * y < 512 * 512);
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && q.size() != 0; i++) @(posedge clk);
    #1;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d results outstanding, expected 0", q.size());
    end
  endtask

  initial begin
    int x, y;
    in_valid  = 1'b0;
    x_in      = '0;
    y_in      = '0;
    out_ready = 1'b1;
    rst       = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    send(1000, 0);
    send(0, 1000);
    send(-1000, 0);
    send(-2048, -2048);
    send(0, 0);
    idle(3);
    send(0, 0);
    drain();

    rand_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rand_xy(x, y);
      send(x, y);
    end
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 2) == 0) idle(1);
      else begin
        rand_xy(x, y);
        send(x, y);
      end
    end
    drain();
    rand_ready = 1'b0;
    idle(2);

    for (int i = 0; i < 5; i++) begin
      rand_xy(x, y);
      send(x, y);
    end
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(20);
    send(1000, 0);
    drain();
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test by %0t, expected completion", $time);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
